// File: rtl/instruction_decode.sv
// instruction_decode: MIPS decode stage with 32-entry register file, control decode and ID/EX register.
module instruction_decode #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           instr_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    input  logic                  instr_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  wb_reg_write,
    input  logic [4:0]            wb_write_reg,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] extended_offset,
    output logic [DATA_WIDTH-1:0] old_address,
    output logic [4:0]            rt_field,
    output logic [4:0]            rd_field,
    output logic [1:0]            ALU_op,
    output logic                  ALU_src,
    output logic                  reg_dst,
    output logic                  branch,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  ex_valid,
    output logic                  illegal
);
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [4:0]            rs, rt;
    logic [5:0]            op;
    logic [DATA_WIDTH-1:0] rf_1, rf_2, sext;
    logic                  is_r, is_lw, is_sw, is_beq, is_addi;
    logic [10:0]           ctrl_d, ctrl_q;
    logic                  wr_en;

    assign rs    = instr_in[25:21];
    assign rt    = instr_in[20:16];
    assign op    = instr_in[31:26];
    assign wr_en = wb_reg_write && wb_write_reg != 5'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Same-cycle write-back is forwarded so decode never sees a stale operand.
    always_comb begin
        rf_1 = rs == 5'd0 ? '0 : (wr_en && wb_write_reg == rs) ? wb_write_data : regs[rs];
        rf_2 = rt == 5'd0 ? '0 : (wr_en && wb_write_reg == rt) ? wb_write_data : regs[rt];
        sext = {{(DATA_WIDTH-16){instr_in[15]}}, instr_in[15:0]};
    end

    assign is_r    = instr_valid && op == 6'b000000;
    assign is_lw   = instr_valid && op == 6'b100011;
    assign is_sw   = instr_valid && op == 6'b101011;
    assign is_beq  = instr_valid && op == 6'b000100;
    assign is_addi = instr_valid && op == 6'b001000;

    // Packed as {ALU_op, ALU_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write, ex_valid, illegal}.
    assign ctrl_d = {is_r, is_beq, is_lw | is_sw | is_addi, is_r, is_beq, is_lw, is_sw, is_lw,
                     is_r | is_lw | is_addi, instr_valid,
                     instr_valid & ~(is_r | is_lw | is_sw | is_beq | is_addi)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_1     <= '0;
            read_data_2     <= '0;
            extended_offset <= '0;
            old_address     <= '0;
            rt_field        <= '0;
            rd_field        <= '0;
            ctrl_q          <= '0;
        end else if (flush || !stall) begin
            read_data_1     <= rf_1;
            read_data_2     <= rf_2;
            extended_offset <= sext;
            old_address     <= pc_plus4_in;
            rt_field        <= rt;
            rd_field        <= instr_in[15:11];
            ctrl_q          <= flush ? '0 : ctrl_d;
        end
    end

    assign {ALU_op, ALU_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write,
            ex_valid, illegal} = ctrl_q;
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage feeding the execute stage of the MIPS datapath. Each cycle it takes one fetched instruction and its PC+4, reads two operands from an internal 32x32 register file, and sign-extends the 16-bit immediate. It generates the main control word (including the 2-bit `ALU_op` and `ALU_src` that the execute stage consumes) and registers all of it into an ID/EX pipeline register. The write-back port of the register file is also here, driven from the write-back stage.

## Interface
Parameters:
- `REG_COUNT`, 32, number of architectural registers; register 0 reads as zero.
- `DATA_WIDTH`, 32, datapath width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_in`  in  32  fetched instruction.
- `pc_plus4_in`  in  32  PC+4 of `instr_in`.
- `instr_valid`  in  1  `instr_in` is a real instruction.
- `stall`  in  1  hold the ID/EX register.
- `flush`  in  1  load a bubble into the ID/EX register.
- `wb_reg_write`  in  1  register file write enable.
- `wb_write_reg`  in  5  register file write index.
- `wb_write_data`  in  32  register file write data.
- `read_data_1`, `read_data_2`  out  32  rs and rt operands.
- `extended_offset`  out  32  sign-extended `instr[15:0]`.
- `old_address`  out  32  registered PC+4.
- `rt_field`, `rd_field`  out  5 each  destination candidates.
- `ALU_op`  out  2  00 = add, 01 = subtract, 10 = decode funct.
- `ALU_src`  out  1  0 selects `read_data_2`, 1 selects `extended_offset`.
- `reg_dst`, `branch`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`  out  1 each  control.
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `illegal`  out  1  registered instruction had an unsupported opcode.

## Operation
Control decode by opcode `instr[31:26]`:
- 000000 (R-type): `reg_dst`=1, `ALU_op`=10, `reg_write`=1, others 0.
- 100011 (lw): `ALU_src`=1, `ALU_op`=00, `mem_read`=1, `mem_to_reg`=1, `reg_write`=1.
- 101011 (sw): `ALU_src`=1, `ALU_op`=00, `mem_write`=1.
- 000100 (beq): `ALU_op`=01, `branch`=1.
- 001000 (addi): `ALU_src`=1, `ALU_op`=00, `reg_write`=1.
- Any other opcode: all control bits 0 and `illegal`=1. This is still a valid slot, so `ex_valid` follows `instr_valid`.
- `instr_valid`=0: bubble. All control bits 0, `ex_valid`=0, `illegal`=0.

Register file:
- Read is combinational on rs = `instr[25:21]` and rt = `instr[20:16]`.
- Write happens on the rising edge when `wb_reg_write`=1 and `wb_write_reg`≠0. Writes to register 0 are discarded.
- Write-through bypass: if a same-cycle write index equals a nonzero read index, the read returns `wb_write_data`.

Other datapath:
- Sign extension: bits 31..16 are copies of `instr[15]`.
- `old_address` is `pc_plus4_in` passed through unchanged.

ID/EX register update priority, evaluated per rising edge: `reset_n` low > `flush` > `stall` > load.
- Flush: all control, `ex_valid` and `illegal` cleared. Data fields may load but are don't-care.
- Stall: every output holds its value. The register file write still occurs.

## Timing
- Latency: the instruction presented in cycle N is visible on the outputs after edge N+1 (one cycle).
- Register file write at edge N is visible to a read in cycle N, through the bypass, and in every later cycle.
- Reset (async assert, sync deassert by the system):
  - All outputs go to 0, including `ALU_op`=00 and `ex_valid`=0.
  - All registers in the register file clear to 0.
- Reset asserted mid-stall or mid-flush overrides both immediately, without waiting for a clock edge.
- `flush` and `stall` asserted together: flush wins, and a bubble is loaded.
- Write during stall: the data is committed. When the stall releases, the held instruction is not re-read; the next loaded instruction sees the new value.

## Test plan
- Reset, then write 0x0000_00A5 to register 8 and read it back:
  - Drive `reset_n`=0 → all outputs 0.
  - Release; write register 8 = 0x0000_00A5; next cycle decode `add $t2,$t0,$t1` (0x01095020) → `read_data_1`=0x0000_00A5, `ALU_op`=10, `reg_dst`=1, `reg_write`=1, `ex_valid`=1.
- Bypass and register 0 protection:
  - Write register 9 = 0x1234 in the same cycle as decoding an instruction reading rt=9 → `read_data_2`=0x1234.
  - Write register 0 = 0xFFFF_FFFF, then read register 0 → 0.
- lw with offset 0xFFFC (0x8D09FFFC) → `extended_offset`=0xFFFF_FFFC, `ALU_src`=1, `ALU_op`=00, `mem_read`=1, `mem_to_reg`=1.
- Branch and illegal opcode:
  - beq (0x11090004) → `ALU_op`=01, `branch`=1, `reg_write`=0.
  - Opcode 0x3F → `illegal`=1, all control 0, `ex_valid`=1.
- Stall and flush:
  - Stall for 3 cycles while `instr_in` changes → outputs frozen.
  - Assert `flush` and `stall` together → next edge gives `ex_valid`=0 and `reg_write`=0.
- Async reset mid-operation: pull `reset_n` low between edges → outputs 0 before the next edge. The register file reads 0 after release.
